// File: rtl/spi_master_m_pkg.sv
// rtl/spi_master_m_pkg.sv - shared SPI state encodings and default geometry
package spi_master_m_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    localparam int SPI_DEF_WIDTH   = 8;
    localparam int SPI_DEF_CLK_DIV = 4;

endpackage

// File: rtl/spi_clk_div_m.sv
// rtl/spi_clk_div_m.sv - half-period tick generator, counts 0..DIV-1 while EN is high
module spi_clk_div_m #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic TICK
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Holding the count at zero while disabled aligns the first tick to the enable edge
    always_ff @(posedge CLK) begin
        if (RST || !EN) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign TICK = EN && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_m.sv
// rtl/spi_master_m.sv - SPI mode-0 LSB-first master, START/BUSY/DONE host handshake
// Optional SPI_MASTER_MISO_SYNC_EN adds a 2-flop MISO synchronizer (needs CLK_DIV >= 3).
module spi_master_m
    import spi_master_m_pkg::*;
#(
    parameter int WIDTH   = SPI_DEF_WIDTH,
    parameter int CLK_DIV = SPI_DEF_CLK_DIV
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] TX_DATA,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             CS,
    output logic             SCK,
    output logic             MOSI,
    input  logic             MISO
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("spi_master_m: WIDTH must be >= 1");
    end

    logic miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
    if (CLK_DIV < 3) begin : g_bad_div
        $error("spi_master_m: CLK_DIV must be >= 3 with the MISO synchronizer");
    end

    logic [1:0] miso_sync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            miso_sync_q <= '0;
        end else begin
            miso_sync_q <= {miso_sync_q[0], MISO};
        end
    end

    assign miso_s = miso_sync_q[1];
`else
    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_master_m: CLK_DIV must be >= 1");
    end

    assign miso_s = MISO;
`endif

    spi_state_e       state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] rx_data_q;
    logic [BW-1:0]    bit_q;
    logic             cs_q;
    logic             sck_q;
    logic             mosi_q;
    logic             busy_q;
    logic             done_q;
    logic             tick;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] rx_d;

    spi_clk_div_m #(
        .DIV (CLK_DIV)
    ) u_clk_div (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (state_q != ST_IDLE),
        .TICK (tick)
    );

    // Received bits enter at the top so that after WIDTH rises bit 0 is the first one
    assign sr_d = sr_q >> 1;
    assign rx_d = WIDTH'({miso_s, rx_q} >> 1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            bit_q     <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START && !busy_q) begin
                        state_q <= ST_LEAD;
                        cs_q    <= 1'b0;
                        mosi_q  <= TX_DATA[0];
                        sr_q    <= TX_DATA;
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LEAD: begin
                    if (tick) begin
                        sck_q   <= 1'b1;
                        rx_q    <= rx_d;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (tick) begin
                        if (sck_q) begin
                            sck_q <= 1'b0;
                            if (bit_q == LAST_BIT) begin
                                state_q <= ST_TRAIL;
                            end else begin
                                sr_q   <= sr_d;
                                mosi_q <= sr_d[0];
                                bit_q  <= bit_q + BW'(1);
                            end
                        end else begin
                            sck_q <= 1'b1;
                            rx_q  <= rx_d;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (tick) begin
                        cs_q      <= 1'b1;
                        mosi_q    <= 1'b0;
                        rx_data_q <= rx_q;
                        done_q    <= 1'b1;
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign RX_DATA = rx_data_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign CS      = cs_q;
    assign SCK     = sck_q;
    assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_m.sv
// tb/tb_spi_master_m.sv - directed and randomized checks of spi_master_m against a slave model
module tb_spi_master_m;

    localparam int W  = 8;
    localparam int D0 = 4;
`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int D1 = 3;
`else
    localparam int D1 = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   start;
    logic [W-1:0] tx  [2];
    logic [W-1:0] rxd [2];
    logic [1:0]   busy, done, cs, sck, mosi, miso;

    always #5 clk = ~clk;

    spi_master_m #(.WIDTH(W), .CLK_DIV(D0)) u_dut0 (
        .CLK(clk), .RST(rst), .START(start[0]), .TX_DATA(tx[0]), .RX_DATA(rxd[0]),
        .BUSY(busy[0]), .DONE(done[0]), .CS(cs[0]), .SCK(sck[0]), .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_master_m #(.WIDTH(W), .CLK_DIV(D1)) u_dut1 (
        .CLK(clk), .RST(rst), .START(start[1]), .TX_DATA(tx[1]), .RX_DATA(rxd[1]),
        .BUSY(busy[1]), .DONE(done[1]), .CS(cs[1]), .SCK(sck[1]), .MOSI(mosi[1]), .MISO(miso[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    int cs_fall_cyc [2], done_cyc [2], busy_low_cyc [2], done_cnt [2], cs_pulses [2];
    int rises [2], mosi_high [2], viol [2], last_mosi_evt [2], idx [2];
    logic [W-1:0] slv_dout [2], slv_din [2], rx_at_done [2];
    logic [1:0]   cs_p, sck_p, mosi_p, busy_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? D0 : D1;
    endfunction

    // MOSI holds bit k for two half-periods; the last bit also spans the trailing half-period
    function automatic int exp_mosi_high(input logic [W-1:0] v, input int dv);
        int c = 0;
        for (int k = 0; k < W - 1; k++) c += v[k] ? 2 * dv : 0;
        c += v[W-1] ? 3 * dv : 0;
        return c;
    endfunction

    // One cycle: observe both DUTs at the falling edge and act as their mode-0 slaves
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (cs_p[d] && !cs[d]) begin
                cs_fall_cyc[d]   = cyc;
                cs_pulses[d]++;
                idx[d]           = 0;
                rises[d]         = 0;
                mosi_high[d]     = 0;
                slv_din[d]       = '0;
                miso[d]          = slv_dout[d][0];
                last_mosi_evt[d] = cyc;
            end
            if (mosi[d] !== mosi_p[d]) begin
                if (!(cs_p[d] && !cs[d]) && !(sck_p[d] && !sck[d]) && !(!cs_p[d] && cs[d]))
                    viol[d]++;
                last_mosi_evt[d] = cyc;
            end
            if (!sck_p[d] && sck[d]) begin
                if (cyc - last_mosi_evt[d] < div_of(d)) viol[d]++;
                if (idx[d] < W) slv_din[d][idx[d]] = mosi[d];
                rises[d]++;
            end
            if (sck_p[d] && !sck[d]) begin
                idx[d]++;
                miso[d] = (idx[d] < W) ? slv_dout[d][idx[d]] : 1'b0;
            end
            if (mosi[d] === 1'b1) mosi_high[d]++;
            if (done[d] === 1'b1) begin
                done_cnt[d]++;
                done_cyc[d]   = cyc;
                rx_at_done[d] = rxd[d];
            end
            if (busy_p[d] && !busy[d]) busy_low_cyc[d] = cyc;
            cs_p[d]   = cs[d];
            sck_p[d]  = sck[d];
            mosi_p[d] = mosi[d];
            busy_p[d] = busy[d];
        end
    endtask

    task automatic wait_idle(input int d, input int n_done);
        int k = 0;
        while ((done_cnt[d] == n_done || busy[d] !== 1'b0) && k < 400) begin
            tick();
            k++;
        end
        check("xfer_timeout", 32'(k < 400), 32'd1);
        repeat (3) tick();
    endtask

    task automatic run_xfer(input int d, input logic [W-1:0] tv, input logic [W-1:0] dv);
        int e0, n, p, dd;
        dd = div_of(d);
        n  = done_cnt[d];
        p  = cs_pulses[d];
        slv_dout[d] = dv;
        tx[d]       = tv;
        start[d]    = 1'b1;
        e0          = cyc + 1;
        tick();
        start[d] = 1'b0;
        tx[d]    = W'($urandom);
        wait_idle(d, n);
        check("accept_cyc", 32'(cs_fall_cyc[d]), 32'(e0));
        check("done_cyc",   32'(done_cyc[d]), 32'(e0 + (2 * W + 1) * dd));
        check("busy_low",   32'(busy_low_cyc[d]), 32'(e0 + (2 * W + 2) * dd));
        check("done_once",  32'(done_cnt[d] - n), 32'd1);
        check("cs_once",    32'(cs_pulses[d] - p), 32'd1);
        check("rx_at_done", 32'(rx_at_done[d]), 32'(dv));
        check("rx_data",    32'(rxd[d]), 32'(dv));
        check("slave_din",  32'(slv_din[d]), 32'(tv));
        check("sck_rises",  32'(rises[d]), 32'(W));
        check("mosi_high",  32'(mosi_high[d]), 32'(exp_mosi_high(tv, dd)));
        check("mosi_rules", 32'(viol[d]), 32'd0);
    endtask

    initial begin
        int e0, p, n;
        logic [W-1:0] tv2, dv1, dv2;

        rst   = 1'b1;
        start = 2'b11;
        tx[0] = 8'hFF;
        tx[1] = 8'hFF;
        miso  = 2'b00;
        for (int d = 0; d < 2; d++) begin
            slv_dout[d] = '0;
            slv_din[d]  = '0;
        end
        repeat (3) tick();
        start = 2'b00;
        for (int d = 0; d < 2; d++) begin
            cs_fall_cyc[d] = 0; done_cyc[d] = 0; busy_low_cyc[d] = 0; done_cnt[d] = 0;
            cs_pulses[d] = 0; rises[d] = 0; mosi_high[d] = 0; viol[d] = 0;
            last_mosi_evt[d] = 0; idx[d] = 0;
            check("rst_cs",   32'(cs[d]),   32'd1);
            check("rst_sck",  32'(sck[d]),  32'd0);
            check("rst_mosi", 32'(mosi[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_done", 32'(done[d]), 32'd0);
            check("rst_rx",   32'(rxd[d]),  32'd0);
        end
        rst = 1'b0;
        tick();

        run_xfer(0, 8'hA5, 8'h3C);
        run_xfer(0, 8'h01, W'($urandom));
        run_xfer(1, 8'h96, 8'h69);
        for (int i = 0; i < 4; i++) begin
            run_xfer(0, W'($urandom), W'($urandom));
            run_xfer(1, W'($urandom), W'($urandom));
        end

        // START while busy is dropped; held START is taken on the first BUSY=0 cycle
        p   = cs_pulses[0];
        dv1 = W'($urandom);
        slv_dout[0] = dv1;
        tx[0]    = 8'h5E;
        start[0] = 1'b1;
        e0       = cyc + 1;
        tick();
        start[0] = 1'b0;
        while (cyc < e0 + 9) tick();
        tx[0]    = 8'hFF;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        while (cyc < e0 + 67) tick();
        start[0] = 1'b1;
        while (cyc < e0 + 72) tick();
        check("ign_pulses", 32'(cs_pulses[0] - p), 32'd1);
        check("ign_done",   32'(done_cyc[0]), 32'(e0 + 68));
        check("ign_rx",     32'(rx_at_done[0]), 32'(dv1));
        check("ign_din",    32'(slv_din[0]), 32'h5E);
        tv2 = W'($urandom);
        dv2 = W'($urandom);
        tx[0]       = tv2;
        slv_dout[0] = dv2;
        n = done_cnt[0];
        tick();
        start[0] = 1'b0;
        check("reaccept_cyc", 32'(cs_fall_cyc[0]), 32'(e0 + 73));
        check("reaccept_pulses", 32'(cs_pulses[0] - p), 32'd2);
        wait_idle(0, n);
        check("reaccept_rx",  32'(rx_at_done[0]), 32'(dv2));
        check("reaccept_din", 32'(slv_din[0]), 32'(tv2));

        // Abort mid-transfer with reset
        n = done_cnt[0];
        slv_dout[0] = W'($urandom);
        tx[0]    = W'($urandom);
        start[0] = 1'b1;
        e0       = cyc + 1;
        tick();
        start[0] = 1'b0;
        while (cyc < e0 + 19) tick();
        check("pre_abort_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_cs",   32'(cs[0]),   32'd1);
        check("abort_sck",  32'(sck[0]),  32'd0);
        check("abort_mosi", 32'(mosi[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_rx",   32'(rxd[0]),  32'd0);
        repeat (100) tick();
        check("abort_no_done", 32'(done_cnt[0] - n), 32'd0);
        run_xfer(0, 8'h5A, 8'hC3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
